usr: RTL and testbench

USR -- requirements
Module: usr

---
 rtl/usr_pkg.sv | 11 +
 rtl/usr_bit_cell.sv | 37 +++
 rtl/usr.sv | 50 +++++
 tb/tb_usr.sv | 138 +++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared mode encodings for the usr universal shift register.
package usr_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHL  = 2'b01,
        SHR  = 2'b10,
        LOAD = 2'b11
    } mode_t;

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit of usr: 4:1 mode mux feeding a flop with async active-high reset.
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       shl_src,
    input  logic       shr_src,
    input  logic       load_src,
    output logic       q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        unique case (mode_t'(sel))
            HOLD: q_d = q_q;
            SHL:  q_d = shl_src;
            SHR:  q_d = shr_src;
            LOAD: q_d = load_src;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/usr.sv
// Universal shift register (hold / shift left / shift right / parallel load).
// Define USR_SERIAL_OUT_EN to add the s_out_left / s_out_right cascade outputs.
module usr
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d_in,
    input  logic             s_in_left,
    input  logic             s_in_right,
    output logic [WIDTH-1:0] q
`ifdef USR_SERIAL_OUT_EN
    ,
    output logic             s_out_left,
    output logic             s_out_right
`endif
);

    logic [WIDTH-1:0] bits_q;
    logic [WIDTH-1:0] shl_src;
    logic [WIDTH-1:0] shr_src;

    // Each bit takes its lower neighbour on SHL and its upper neighbour on SHR;
    // the serial inputs fill the vacated end.
    assign shl_src = {bits_q[WIDTH-2:0], s_in_right};
    assign shr_src = {s_in_left, bits_q[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usr_bit_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .sel      (sel),
            .shl_src  (shl_src[i]),
            .shr_src  (shr_src[i]),
            .load_src (d_in[i]),
            .q        (bits_q[i])
        );
    end

    assign q = bits_q;

`ifdef USR_SERIAL_OUT_EN
    assign s_out_left  = bits_q[WIDTH-1];
    assign s_out_right = bits_q[0];
`endif

endmodule

// File: tb/tb_usr.sv
// Directed self-checking bench for usr (WIDTH=4); serial-out checks need USR_SERIAL_OUT_EN.
module tb_usr;

    logic       clk;
    logic       rst;
    logic [1:0] sel;
    logic [3:0] d_in;
    logic       s_in_left;
    logic       s_in_right;
    logic [3:0] q;
`ifdef USR_SERIAL_OUT_EN
    logic       s_out_left;
    logic       s_out_right;
`endif

    int unsigned n_checks;
    int unsigned n_fail;

    usr #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .d_in       (d_in),
        .s_in_left  (s_in_left),
        .s_in_right (s_in_right),
        .q          (q)
`ifdef USR_SERIAL_OUT_EN
        ,
        .s_out_left (s_out_left),
        .s_out_right(s_out_right)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic [1:0] s, input logic [3:0] d, input logic sl, input logic sr);
        sel        = s;
        d_in       = d;
        s_in_left  = sl;
        s_in_right = sr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        sel        = 2'b11;
        d_in       = 4'b1111;
        s_in_left  = 1'b1;
        s_in_right = 1'b1;

        // Reset held: q stays zero between and across edges regardless of inputs.
        #2;
        check("rst_between_edges", 64'(q), 64'h0);
        @(posedge clk); #1;
        check("rst_after_edge_load", 64'(q), 64'h0);
        sel = 2'b01;
        @(posedge clk); #1;
        check("rst_after_edge_shl", 64'(q), 64'h0);

        // Release between edges: nothing changes until the next edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_no_edge", 64'(q), 64'h0);

        step(2'b11, 4'b1101, 1'b0, 1'b0);
        check("load_1101", 64'(q), 64'hD);
        step(2'b10, 4'b0000, 1'b1, 1'b0);
        check("shr_in1_1110", 64'(q), 64'hE);
        step(2'b01, 4'b1111, 1'b1, 1'b0);
        check("shl_in0_1100", 64'(q), 64'hC);
        step(2'b00, 4'b0011, 1'b1, 1'b1);
        check("hold_1100", 64'(q), 64'hC);
        step(2'b10, 4'b1111, 1'b0, 1'b1);
        check("shr_in0_0110", 64'(q), 64'h6);
        step(2'b01, 4'b0000, 1'b0, 1'b1);
        check("shl_in1_1101", 64'(q), 64'hD);
        step(2'b01, 4'b0000, 1'b0, 1'b1);
        check("shl_msb_drop_1011", 64'(q), 64'hB);
        step(2'b10, 4'b1111, 1'b0, 1'b0);
        check("shr_lsb_drop_0101", 64'(q), 64'h5);
        step(2'b11, 4'b0000, 1'b1, 1'b1);
        check("load_0000", 64'(q), 64'h0);
        step(2'b11, 4'b1111, 1'b0, 1'b0);
        check("load_1111", 64'(q), 64'hF);

        // Reset asserted mid-shift between edges clears at once.
        step(2'b01, 4'b0000, 1'b0, 1'b0);
        check("shl_seq_1110", 64'(q), 64'hE);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_clear", 64'(q), 64'h0);
        @(posedge clk); #1;
        check("rst_hold_during_shl", 64'(q), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        s_in_right = 1'b1;
        #1;
        check("rst_release_wait", 64'(q), 64'h0);
        @(posedge clk); #1;
        check("resume_shl_0001", 64'(q), 64'h1);

`ifdef USR_SERIAL_OUT_EN
        step(2'b11, 4'b1001, 1'b0, 1'b0);
        check("so_q_1001", 64'(q), 64'h9);
        check("so_left_1", 64'(s_out_left), 64'h1);
        check("so_right_1", 64'(s_out_right), 64'h1);
        step(2'b01, 4'b1111, 1'b1, 1'b0);
        check("so_q_0010", 64'(q), 64'h2);
        check("so_left_0", 64'(s_out_left), 64'h0);
        check("so_right_0", 64'(s_out_right), 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
